// File: rtl/electron_nest_if.sv
// electron_nest_if: load/store token bus for electron_nest.
// Forward token layout (MSB first): {v, a, r, c, i[WIDTH_EXADDR], d[WIDTH_DATA]}.
// Back token layout (MSB first):    {n, t, v, c}.
// slave = design view, master = environment view.
interface electron_nest_if #(
   parameter int unsigned WIDTH_DATA   = 32,
   parameter int unsigned WIDTH_EXADDR = 12
);
   localparam int unsigned FTK_W = WIDTH_DATA + WIDTH_EXADDR + 4;

   logic                    I_Boot;
   logic                    O_Ld_Req;
   logic [WIDTH_EXADDR-1:0] O_Ld_Addr;
   logic [FTK_W-1:0]        I_Ld_FTk;
   logic [3:0]              O_Ld_BTk;
   logic                    O_St_Req;
   logic [WIDTH_EXADDR-1:0] O_St_Addr;
   logic [FTK_W-1:0]        O_St_FTk;
   logic [3:0]              I_St_BTk;

   modport slave (
      input  I_Boot, I_Ld_FTk, I_St_BTk,
      output O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk
   );

   modport master (
      output I_Boot, I_Ld_FTk, I_St_BTk,
      input  O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk
   );
endinterface

// File: rtl/electron_nest.sv
// electron_nest: boot-configured block copy / scale engine.
// A boot token (v=1, a=1) starts a boot sequence: two preamble tokens are
// dropped, then five config words (source, destination, length, multiplier,
// mode) are captured. RUN streams loads (fixed one-cycle return latency)
// through an optional multiply into a 4-entry store FIFO; the FIFO head is
// presented on the store port and popped whenever the store side does not nack.
// Build option: EXTEND_MEM_EN -- store address is rebuilt from the returned
// token index and also carried in the store token's i field.
module electron_nest #(
   parameter int unsigned WIDTH_DATA   = 32,
   parameter int unsigned WIDTH_EXADDR = 12
) (
   input  logic           clock,
   input  logic           reset,
   electron_nest_if.slave bus
);

   typedef struct packed {
      logic                    v;
      logic                    a;
      logic                    r;
      logic                    c;
      logic [WIDTH_EXADDR-1:0] i;
      logic [WIDTH_DATA-1:0]   d;
   } ftk_t;

   typedef struct packed {
      logic n;
      logic t;
      logic v;
      logic c;
   } btk_t;

   typedef enum logic [1:0] {IDLE, BOOT, RUN, DRAIN} state_t;

   localparam logic [WIDTH_DATA-1:0] ONE_D = 1;

   ftk_t ld_tk;
   btk_t st_bk;

   assign ld_tk = bus.I_Ld_FTk;
   assign st_bk = bus.I_St_BTk;

   state_t                  state_q;
   logic [2:0]              boot_cnt_q;
   logic [WIDTH_EXADDR-1:0] src_q;
   logic [WIDTH_EXADDR-1:0] dst_q;
   logic [WIDTH_DATA-1:0]   len_q;
   logic [WIDTH_DATA-1:0]   mul_q;
   logic                    mode_q;
   logic [WIDTH_DATA-1:0]   k_q;
   logic [WIDTH_DATA-1:0]   s_q;
   logic                    ld_req_q;
   logic [WIDTH_EXADDR-1:0] ld_addr_q;
   logic                    inflight_q;

   logic [WIDTH_DATA-1:0]   fifo_d_q [4];
`ifdef EXTEND_MEM_EN
   logic [WIDTH_EXADDR-1:0] fifo_a_q [4];
`endif
   logic [1:0]              wr_ptr_q;
   logic [1:0]              rd_ptr_q;
   logic [2:0]              count_q;
   logic [2:0]              count_d;

   logic                    push;
   logic                    pop;
   logic                    issue;
   logic [WIDTH_DATA-1:0]   prod;
   logic [WIDTH_DATA-1:0]   result;
   logic [WIDTH_EXADDR-1:0] st_addr;
   ftk_t                    st_tk;

   // FIFO handshake, load throttle and the word to be pushed this cycle.
   // The throttle looks at next-cycle occupancy plus the request returning
   // next cycle, so a load issued next cycle always has a free slot.
   always_comb begin
      push    = ((state_q == RUN) || (state_q == DRAIN)) && inflight_q && ld_tk.v;
      pop     = (count_q != 3'd0) && !st_bk.n;
      count_d = count_q + {2'b00, push} - {2'b00, pop};
      issue   = (state_q == RUN) && (k_q < len_q)
                && ((count_d + {2'b00, ld_req_q}) < 3'd4);
      prod    = ld_tk.d * mul_q;
      result  = mode_q ? prod : ld_tk.d;
   end

   // Control FSM: boot capture, load issue and completion, registered load outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         boot_cnt_q <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         mul_q      <= '0;
         mode_q     <= 1'b0;
         k_q        <= '0;
         s_q        <= '0;
         ld_req_q   <= 1'b0;
         ld_addr_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         ld_req_q   <= 1'b0;
         ld_addr_q  <= '0;
         inflight_q <= ld_req_q;
         if (pop) begin
            s_q <= s_q + ONE_D;
         end
         unique case (state_q)
            IDLE: begin
               if (ld_tk.v && ld_tk.a) begin
                  state_q    <= BOOT;
                  boot_cnt_q <= '0;
               end
            end
            BOOT: begin
               if (ld_tk.v) begin
                  boot_cnt_q <= boot_cnt_q + 3'd1;
                  case (boot_cnt_q)
                     3'd2: src_q <= ld_tk.d[WIDTH_EXADDR-1:0];
                     3'd3: dst_q <= ld_tk.d[WIDTH_EXADDR-1:0];
                     3'd4: len_q <= ld_tk.d;
                     3'd5: mul_q <= ld_tk.d;
                     3'd6: begin
                        mode_q  <= ld_tk.d[0];
                        k_q     <= '0;
                        s_q     <= '0;
                        state_q <= (len_q == '0) ? IDLE : RUN;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (issue) begin
                  ld_req_q  <= 1'b1;
                  ld_addr_q <= src_q + k_q[WIDTH_EXADDR-1:0];
                  k_q       <= k_q + ONE_D;
                  if ((k_q + ONE_D) == len_q) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && ((s_q + ONE_D) == len_q)) begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   // Store FIFO storage and pointers; push and pop may share an edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned e = 0; e < 4; e++) begin
            fifo_d_q[e] <= '0;
`ifdef EXTEND_MEM_EN
            fifo_a_q[e] <= '0;
`endif
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_d_q[wr_ptr_q] <= result;
`ifdef EXTEND_MEM_EN
            fifo_a_q[wr_ptr_q] <= dst_q + (ld_tk.i - src_q);
`endif
            wr_ptr_q <= wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         count_q <= count_d;
      end
   end

   // Store port presents the FIFO head; everything is zero while the FIFO is empty.
   always_comb begin
      st_tk = '0;
`ifdef EXTEND_MEM_EN
      st_addr = fifo_a_q[rd_ptr_q];
`else
      st_addr = dst_q + s_q[WIDTH_EXADDR-1:0];
`endif
      if (count_q != 3'd0) begin
         st_tk.v = 1'b1;
         st_tk.d = fifo_d_q[rd_ptr_q];
`ifdef EXTEND_MEM_EN
         st_tk.i = st_addr;
`endif
      end
   end

   assign bus.O_Ld_Req  = ld_req_q;
   assign bus.O_Ld_Addr = ld_addr_q;
   assign bus.O_Ld_BTk  = '0;
   assign bus.O_St_Req  = (count_q != 3'd0);
   assign bus.O_St_Addr = (count_q != 3'd0) ? st_addr : '0;
   assign bus.O_St_FTk  = st_tk;

   logic unused_bits;
`ifdef EXTEND_MEM_EN
   assign unused_bits = ^{bus.I_Boot, ld_tk.r, ld_tk.c, st_bk.t, st_bk.v, st_bk.c};
`else
   assign unused_bits = ^{bus.I_Boot, ld_tk.r, ld_tk.c, ld_tk.i, st_bk.t, st_bk.v, st_bk.c};
`endif

endmodule

// File: tb/tb_electron_nest.sv
// tb_electron_nest: scoreboard bench for electron_nest.
// Stimulus pushes expected loads/stores (from a word-level model of the
// transfer) into queues; a negedge monitor pops and compares every load
// request and every accepted store. A responder returns memory words one
// cycle after each load request.
module tb_electron_nest;
   localparam int unsigned WD = 32;
   localparam int unsigned WA = 12;
   localparam int unsigned FW = WD + WA + 4;

   logic clk;
   logic rst_n;

   electron_nest_if #(.WIDTH_DATA(WD), .WIDTH_EXADDR(WA)) bus ();

   electron_nest #(.WIDTH_DATA(WD), .WIDTH_EXADDR(WA)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int               checks = 0;
   int               errors = 0;
   logic [WD-1:0]    mem [4096];
   logic [FW-1:0]    tok_q [$];
   logic [WA-1:0]    exp_ld_q [$];
   logic [WA+FW-1:0] exp_st_q [$];
   int               ld_cycles [$];
   int               st_cycles [$];
   int               cyc = 0;
   logic             ld_seen = 1'b0;
   logic [WA-1:0]    ld_seen_addr = '0;
   int               stall_start = 1 << 30;
   int               stall_len = 0;
   int               stall_pct = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic v, input logic a, input logic [WD-1:0] d);
      return {v, a, 2'b00, WA'(0), d};
   endfunction

   // Input driver: load returns take priority, otherwise queued boot tokens.
   initial begin
      logic stall_bit;
      bus.I_Boot   = 1'b0;
      bus.I_Ld_FTk = '0;
      bus.I_St_BTk = '0;
      forever begin
         @(posedge clk);
         #1;
         if (ld_seen) begin
            bus.I_Ld_FTk = {1'b1, 3'b000, ld_seen_addr, mem[ld_seen_addr]};
            bus.I_Boot   = 1'b0;
         end else if (tok_q.size() > 0) begin
            bus.I_Ld_FTk = tok_q.pop_front();
            bus.I_Boot   = 1'b1;
         end else begin
            bus.I_Ld_FTk = '0;
            bus.I_Boot   = 1'b0;
         end
         stall_bit = ((cyc + 1 >= stall_start) && (cyc + 1 < stall_start + stall_len))
                     || (int'($urandom_range(0, 99)) < stall_pct);
         bus.I_St_BTk = {stall_bit, 3'b000};
      end
   end

   // Monitor: compares every load request and every accepted store.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         ld_seen      = rst_n && bus.O_Ld_Req;
         ld_seen_addr = bus.O_Ld_Addr;
         if (rst_n && bus.O_Ld_Req) begin
            ld_cycles.push_back(cyc);
            if (exp_ld_q.size() == 0) check("unexpected_load", 64'd1, 64'd0);
            else check("load_addr", 64'(bus.O_Ld_Addr), 64'(exp_ld_q.pop_front()));
         end
         if (rst_n && bus.O_St_Req && !bus.I_St_BTk[3]) begin
            st_cycles.push_back(cyc);
            if (exp_st_q.size() == 0) check("unexpected_store", 64'd1, 64'd0);
            else check("store_addr_token", 64'({bus.O_St_Addr, bus.O_St_FTk}),
                       64'(exp_st_q.pop_front()));
         end
      end
   end

   // Reference model: word j of the transfer reads src+j and writes dst+j.
   task automatic plan(input logic [WA-1:0] src, input logic [WA-1:0] dst, input int n,
                       input logic [WD-1:0] m, input logic mode);
      logic [63:0]   prod;
      logic [WA-1:0] sa;
      logic [WA-1:0] da;
      logic [WA-1:0] ti;
      logic [WD-1:0] res;
      for (int j = 0; j < n; j++) begin
         sa   = src + WA'(j);
         da   = dst + WA'(j);
         prod = 64'(mem[sa]) * 64'(m);
         res  = mode ? prod[WD-1:0] : mem[sa];
`ifdef EXTEND_MEM_EN
         ti = da;
`else
         ti = '0;
`endif
         exp_ld_q.push_back(sa);
         exp_st_q.push_back({da, 1'b1, 3'b000, ti, res});
      end
   endtask

   task automatic gap();
      if ($urandom_range(0, 2) == 0)
         tok_q.push_back({1'b0, 3'($urandom()), WA'($urandom()), WD'($urandom())});
   endtask

   task automatic boot(input logic [WD-1:0] c0, input logic [WD-1:0] c1, input logic [WD-1:0] c2,
                       input logic [WD-1:0] c3, input logic [WD-1:0] c4);
      logic [WD-1:0] cfg [5];
      cfg[0] = c0; cfg[1] = c1; cfg[2] = c2; cfg[3] = c3; cfg[4] = c4;
      tok_q.push_back(mk(1'b1, 1'b1, $urandom()));
      gap();
      tok_q.push_back(mk(1'b1, 1'b0, '0));
      gap();
      tok_q.push_back(mk(1'b1, 1'b0, '0));
      for (int j = 0; j < 5; j++) begin
         gap();
         tok_q.push_back(mk(1'b1, 1'b0, cfg[j]));
      end
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_st_q.size() != 0 || tok_q.size() != 0) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check({name, "_complete"}, 64'(t < 3000), 64'd1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check({name, "_st_req_idle"}, 64'(bus.O_St_Req), 64'd0);
   endtask

   function automatic int max_outstanding(input int lb, input int sb);
      int mx = 0;
      for (int a = lb; a < ld_cycles.size(); a++) begin
         int s = 0;
         for (int b = sb; b < st_cycles.size(); b++)
            if (st_cycles[b] < ld_cycles[a]) s++;
         if ((a - lb + 1) - s > mx) mx = (a - lb + 1) - s;
      end
      return mx;
   endfunction

   task automatic xfer(input string name, input logic [WA-1:0] src, input logic [WA-1:0] dst,
                       input int n, input logic [WD-1:0] m, input logic [WD-1:0] c4,
                       input int pct, input bit stall_mid);
      int lb = ld_cycles.size();
      int sb = st_cycles.size();
      int t  = 0;
      int mo;
      plan(src, dst, n, m, c4[0]);
      boot(WD'(src), WD'(dst), WD'(n), m, c4);
      stall_pct = pct;
      if (stall_mid) begin
         while (ld_cycles.size() <= lb && t < 300) begin
            @(posedge clk);
            t++;
         end
         check({name, "_first_load"}, 64'(t < 300), 64'd1);
         if (ld_cycles.size() > lb) begin
            stall_start = ld_cycles[lb] + 3;
            stall_len   = 5;
         end
      end
      wait_drain(name);
      stall_pct = 0;
      stall_len = 0;
      check({name, "_ld_count"}, 64'(ld_cycles.size() - lb), 64'(n));
      check({name, "_st_count"}, 64'(st_cycles.size() - sb), 64'(n));
      mo = max_outstanding(lb, sb);
      if (stall_mid) check({name, "_max_outstanding"}, 64'(mo), 64'd4);
      else check({name, "_outstanding_le4"}, 64'(mo <= 4), 64'd1);
      if (pct == 0 && !stall_mid && n > 0 && ld_cycles.size() >= lb + n && st_cycles.size() > sb) begin
         check({name, "_ld_consecutive"}, 64'(ld_cycles[lb + n - 1] - ld_cycles[lb]), 64'(n - 1));
         check({name, "_first_store_latency"}, 64'(st_cycles[sb] - ld_cycles[lb]), 64'd2);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_ld_req"},  64'(bus.O_Ld_Req),  64'd0);
      check({name, "_ld_addr"}, 64'(bus.O_Ld_Addr), 64'd0);
      check({name, "_ld_btk"},  64'(bus.O_Ld_BTk),  64'd0);
      check({name, "_st_req"},  64'(bus.O_St_Req),  64'd0);
      check({name, "_st_addr"}, 64'(bus.O_St_Addr), 64'd0);
      check({name, "_st_ftk"},  64'(bus.O_St_FTk),  64'd0);
   endtask

   initial begin
      logic [WA-1:0] src;
      logic [WA-1:0] dst;
      int            t;
      int            sb;
      rst_n = 1'b0;
      for (int a = 0; a < 4096; a++) mem[a] = $urandom();
      repeat (3) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Stray tokens while idle: valid without acquire, acquire without valid.
      tok_q.push_back(mk(1'b1, 1'b0, $urandom()));
      tok_q.push_back(mk(1'b0, 1'b1, $urandom()));
      tok_q.push_back(mk(1'b1, 1'b0, 32'h7));
      repeat (5) @(posedge clk);

      for (int j = 0; j < 4; j++) mem[12'h100 + j] = WD'(j + 1);
      xfer("mul4", 12'h100, 12'h200, 4, 32'd3, 32'd1, 0, 1'b0);
      xfer("copy4", 12'h100, 12'h200, 4, 32'd3, 32'd0, 0, 1'b0);
      xfer("zero_len", 12'h100, 12'h200, 0, 32'd3, 32'd1, 0, 1'b0);
      xfer("after_zero", 12'h100, 12'h240, 2, 32'd5, 32'hFFFF_FFFF, 0, 1'b0);
      xfer("stall8", 12'h300, 12'h400, 8, 32'd5, 32'd1, 0, 1'b1);

      mem[12'h500] = 32'h0001_0001;
      xfer("trunc", 12'h500, 12'h600, 1, 32'h0001_0000, 32'd1, 0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         src = (r == 0) ? 12'hFFE : WA'($urandom());
         dst = (r == 0) ? 12'hFFD : WA'($urandom());
         xfer("rand", src, dst, int'($urandom_range(1, 12)), $urandom(),
              {$urandom_range(0, 7), 1'($urandom())}, (r % 2 == 0) ? 30 : 0, 1'b0);
      end

      // Reset in the middle of a transfer.
      sb = st_cycles.size();
      plan(12'h700, 12'h800, 10, 32'd7, 1'b1);
      boot(32'h700, 32'h800, 32'd10, 32'd7, 32'd1);
      t = 0;
      while (st_cycles.size() < sb + 3 && t < 300) begin
         @(posedge clk);
         t++;
      end
      check("midrun_reached", 64'(t < 300), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrun_reset");
      exp_st_q.delete();
      exp_ld_q.delete();
      tok_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      xfer("post_reset", 12'h700, 12'h900, 6, 32'd9, 32'd1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
